// File: rtl/affine_stencil_ub.sv
// affine_stencil_ub
//
// Unified buffer that sits between a producer and a consumer compute op. It
// has one write port and one multi-tap stencil read port. Each port owns a
// DIMS-deep odometer counter, so the datapath only supplies enables and data.
// The addresses are affine functions of those counters.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   flush          synchronous restart of both generators; RAM is untouched
//   wr_extent/wr_stride/wr_offset      write loop nest configuration
//   rd_extent/rd_stride/rd_tap_offset  read loop nest and per-tap bases
//   wr_en, wr_data                     write beat
//   rd_en                              request one stencil read
//   rd_data, rd_valid                  registered tap data and its strobe
//   wr_done, rd_done                   iteration domain exhausted
//   wr_overrun, rd_overrun             sticky: enable seen while done

module affine_stencil_ub #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4096,
    parameter int DIMS   = 3,
    parameter int TAPS   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [DIMS-1:0][CNT_W-1:0]        wr_extent,
    input  logic [DIMS-1:0][CNT_W-1:0]        wr_stride,
    input  logic [CNT_W-1:0]                  wr_offset,
    input  logic [DIMS-1:0][CNT_W-1:0]        rd_extent,
    input  logic [DIMS-1:0][CNT_W-1:0]        rd_stride,
    input  logic [TAPS-1:0][CNT_W-1:0]        rd_tap_offset,
    input  logic                              wr_en,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              rd_en,
    output logic [TAPS-1:0][WIDTH-1:0]        rd_data,
    output logic                              rd_valid,
    output logic                              wr_done,
    output logic                              rd_done,
    output logic                              wr_overrun,
    output logic                              rd_overrun
);

    // Address sums are formed wide enough that no term or partial sum can
    // overflow before truncation to the RAM address.
    localparam int SUM_W = 2 * CNT_W + $clog2(DIMS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef logic [DIMS-1:0][CNT_W-1:0] idx_t;

    // An extent of 0 behaves like 1, so its last index is 0.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] e);
        return (e == '0) ? '0 : e - CNT_W'(1);
    endfunction

    function automatic logic odo_last(input idx_t idx, input idx_t extent);
        logic last;
        last = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (idx[d] < last_of(extent[d])) last = 1'b0;
        end
        return last;
    endfunction

    // Odometer step: innermost dim increments, wrapped dims carry outward.
    // Carry out of the top dim leaves every index at zero.
    function automatic idx_t odo_next(input idx_t idx, input idx_t extent);
        idx_t nxt;
        logic carry;
        carry = 1'b1;
        nxt   = idx;
        for (int d = 0; d < DIMS; d++) begin
            if (carry) begin
                if (idx[d] >= last_of(extent[d])) begin
                    nxt[d] = '0;
                end else begin
                    nxt[d] = idx[d] + CNT_W'(1);
                    carry  = 1'b0;
                end
            end
        end
        return nxt;
    endfunction

    function automatic logic [ADDR_W-1:0] affine_addr(input logic [CNT_W-1:0] base,
                                                      input idx_t idx,
                                                      input idx_t stride);
        logic [SUM_W-1:0] acc;
        acc = SUM_W'(base);
        for (int d = 0; d < DIMS; d++) begin
            acc = acc + SUM_W'(idx[d]) * SUM_W'(stride[d]);
        end
        return ADDR_W'(acc);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    state_t wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    idx_t   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic   wr_overrun_q, wr_overrun_d, rd_overrun_q, rd_overrun_d;
    logic   rd_valid_q, rd_valid_d;
    logic   wr_fire, rd_fire;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [TAPS-1:0][ADDR_W-1:0]       rd_addr;
    logic [TAPS-1:0][WIDTH-1:0]        rd_data_q, rd_data_d;

    // Addresses use the counter values before this beat's increment.
    always_comb begin
        wr_addr = affine_addr(wr_offset, wr_idx_q, wr_stride);
        for (int t = 0; t < TAPS; t++) begin
            rd_addr[t] = affine_addr(rd_tap_offset[t], rd_idx_q, rd_stride);
        end
    end

    // Write generator. Flush wins over a same-cycle wr_en.
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_idx_d     = wr_idx_q;
        wr_overrun_d = wr_overrun_q;
        wr_fire      = 1'b0;
        if (flush) begin
            wr_state_d   = ST_IDLE;
            wr_idx_d     = '0;
            wr_overrun_d = 1'b0;
        end else if (wr_en) begin
            if (wr_state_q == ST_DONE) begin
                wr_overrun_d = 1'b1;
            end else begin
                wr_fire    = 1'b1;
                wr_idx_d   = odo_next(wr_idx_q, wr_extent);
                wr_state_d = odo_last(wr_idx_q, wr_extent) ? ST_DONE : ST_RUN;
            end
        end
    end

    // Read generator plus the registered tap data. rd_data keeps its old
    // value whenever no read is accepted, including across flush.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_idx_d     = rd_idx_q;
        rd_overrun_d = rd_overrun_q;
        rd_fire      = 1'b0;
        rd_data_d    = rd_data_q;
        if (flush) begin
            rd_state_d   = ST_IDLE;
            rd_idx_d     = '0;
            rd_overrun_d = 1'b0;
        end else if (rd_en) begin
            if (rd_state_q == ST_DONE) begin
                rd_overrun_d = 1'b1;
            end else begin
                rd_fire    = 1'b1;
                rd_idx_d   = odo_next(rd_idx_q, rd_extent);
                rd_state_d = odo_last(rd_idx_q, rd_extent) ? ST_DONE : ST_RUN;
            end
        end
        if (rd_fire) begin
            for (int t = 0; t < TAPS; t++) begin
                rd_data_d[t] = mem[rd_addr[t]];
            end
        end
        rd_valid_d = rd_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q   <= ST_IDLE;
            rd_state_q   <= ST_IDLE;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_overrun_q <= 1'b0;
            rd_overrun_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_overrun_q <= wr_overrun_d;
            rd_overrun_q <= rd_overrun_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage has no reset. Reads sample mem in the same edge as this write,
    // so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_data;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign wr_done    = (wr_state_q == ST_DONE);
    assign rd_done    = (rd_state_q == ST_DONE);
    assign wr_overrun = wr_overrun_q;
    assign rd_overrun = rd_overrun_q;

endmodule

// File: tb/tb_affine_stencil_ub.sv
// Testbench for affine_stencil_ub: scenario tasks with a read scoreboard.
module tb_affine_stencil_ub;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16384;
    localparam int DIMS  = 3;
    localparam int TAPS  = 4;
    localparam int CNT_W = 16;

    typedef logic [TAPS-1:0][WIDTH-1:0] taps_t;

    logic clk = 1'b0;
    logic rst_n, flush, wr_en, rd_en, rd_valid;
    logic wr_done, rd_done, wr_overrun, rd_overrun;
    logic [DIMS-1:0][CNT_W-1:0] wr_extent, wr_stride, rd_extent, rd_stride;
    logic [TAPS-1:0][CNT_W-1:0] rd_tap_offset;
    logic [CNT_W-1:0] wr_offset;
    logic [WIDTH-1:0] wr_data;
    taps_t rd_data;

    taps_t exp_q[$];
    logic [WIDTH-1:0] mdl [DEPTH];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    affine_stencil_ub #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DIMS(DIMS), .TAPS(TAPS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_extent(wr_extent), .wr_stride(wr_stride), .wr_offset(wr_offset),
        .rd_extent(rd_extent), .rd_stride(rd_stride), .rd_tap_offset(rd_tap_offset),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_done(wr_done), .rd_done(rd_done),
        .wr_overrun(wr_overrun), .rd_overrun(rd_overrun)
    );

    function automatic int ext_of(input logic [CNT_W-1:0] e);
        return (e == 0) ? 1 : int'(e);
    endfunction

    // Beat n decomposed into loop indices by division, then mapped to address.
    function automatic int wr_addr_of(input int n);
        int i0, i1, i2;
        i0 = n % ext_of(wr_extent[0]);
        n  = n / ext_of(wr_extent[0]);
        i1 = n % ext_of(wr_extent[1]);
        i2 = (n / ext_of(wr_extent[1])) % ext_of(wr_extent[2]);
        return (int'(wr_offset) + i0 * int'(wr_stride[0]) + i1 * int'(wr_stride[1])
                + i2 * int'(wr_stride[2])) % DEPTH;
    endfunction

    function automatic taps_t expect_read(input int n);
        int i0, i1, i2, base;
        taps_t e;
        i0 = n % ext_of(rd_extent[0]);
        n  = n / ext_of(rd_extent[0]);
        i1 = n % ext_of(rd_extent[1]);
        i2 = (n / ext_of(rd_extent[1])) % ext_of(rd_extent[2]);
        base = i0 * int'(rd_stride[0]) + i1 * int'(rd_stride[1]) + i2 * int'(rd_stride[2]);
        for (int t = 0; t < TAPS; t++) e[t] = mdl[(int'(rd_tap_offset[t]) + base) % DEPTH];
        return e;
    endfunction

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        wr_extent = '0; wr_stride = '0; wr_offset = '0;
        rd_extent = '0; rd_stride = '0; rd_tap_offset = '0;
        #1;
        n_cmp++; if (rd_data !== '0)   begin n_fail++; $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (wr_done !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_wr_done got %b want 0", wr_done); end
        n_cmp++; if (rd_done !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_rd_done got %b want 0", rd_done); end
        n_cmp++; if (wr_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_overrun got %b want 0", wr_overrun); end
        n_cmp++; if (rd_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_overrun got %b want 0", rd_overrun); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_downsample();
        taps_t want, lit;
        int popped;
        wr_offset = 0;
        wr_extent[0] = 64; wr_extent[1] = 64;  wr_extent[2] = 4;
        wr_stride[0] = 1;  wr_stride[1] = 64;  wr_stride[2] = 4096;
        rd_extent[0] = 32; rd_extent[1] = 32;  rd_extent[2] = 4;
        rd_stride[0] = 2;  rd_stride[1] = 128; rd_stride[2] = 4096;
        rd_tap_offset[0] = 0; rd_tap_offset[1] = 1; rd_tap_offset[2] = 65; rd_tap_offset[3] = 64;
        do_flush();
        for (int c = 0; c <= 16384; c++) begin
            @(negedge clk);
            if (c == 16383 || c == 16384) begin
                n_cmp++;
                if (wr_done !== (c == 16384)) begin
                    n_fail++; $display("[TB] FAIL ds_wr_done after %0d writes got %b want %b", c, wr_done, c == 16384);
                end
            end
            if (c < 16384) begin
                wr_en = 1'b1; wr_data = WIDTH'(c);
                mdl[wr_addr_of(c)] = WIDTH'(c);
            end else begin
                wr_en = 1'b0;
            end
        end
        popped = 0;
        for (int c = 0; c <= 4097; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL ds_unexpected_valid got 1 want 0");
                end else begin
                    want = exp_q.pop_front();
                    if (rd_data !== want) begin
                        n_fail++; $display("[TB] FAIL ds_data[%0d] got %h want %h", popped, rd_data, want);
                    end
                    if (popped == 0 || popped == 1 || popped == 32) begin
                        if (popped == 0)      lit = {16'd64, 16'd65, 16'd1, 16'd0};
                        else if (popped == 1) lit = {16'd66, 16'd67, 16'd3, 16'd2};
                        else                  lit = {16'd192, 16'd193, 16'd129, 16'd128};
                        n_cmp++;
                        if (rd_data !== lit) begin
                            n_fail++; $display("[TB] FAIL ds_literal[%0d] got %h want %h", popped, rd_data, lit);
                        end
                    end
                    popped++;
                end
            end
            if (c == 4095 || c == 4096) begin
                n_cmp++;
                if (rd_done !== (c == 4096)) begin
                    n_fail++; $display("[TB] FAIL ds_rd_done after %0d reads got %b want %b", c, rd_done, c == 4096);
                end
            end
            if (c == 4097) begin
                n_cmp++;
                if (rd_valid !== 1'b0 || popped != 4096) begin
                    n_fail++; $display("[TB] FAIL ds_drain got valid=%b reads=%0d want valid=0 reads=4096", rd_valid, popped);
                end
            end
            if (c < 4096) begin
                rd_en = 1'b1;
                exp_q.push_back(expect_read(c));
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    // Write beat c and read beat c-1 in the same cycle: one-cycle write latency
    // and full throughput on both ports at once.
    task automatic test_passthrough();
        taps_t want;
        int popped;
        logic [WIDTH-1:0] d;
        wr_offset = 0;
        for (int k = 0; k < DIMS; k++) begin
            wr_extent[k] = (k == 2) ? 16'd4 : 16'd32;
            rd_extent[k] = wr_extent[k];
        end
        wr_stride[0] = 1; wr_stride[1] = 32; wr_stride[2] = 1024;
        rd_stride = wr_stride;
        rd_tap_offset = '0;
        do_flush();
        popped = 0;
        for (int c = 0; c <= 4098; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL pt_unexpected_valid got 1 want 0");
                end else begin
                    want = exp_q.pop_front();
                    if (rd_data !== want) begin
                        n_fail++; $display("[TB] FAIL pt_data[%0d] got %h want %h", popped, rd_data, want);
                    end
                    popped++;
                end
            end
            if (c == 4095 || c == 4096) begin
                n_cmp++;
                if (wr_done !== (c == 4096)) begin
                    n_fail++; $display("[TB] FAIL pt_wr_done after %0d writes got %b want %b", c, wr_done, c == 4096);
                end
            end
            if (c >= 1 && c <= 4096) begin
                rd_en = 1'b1;
                exp_q.push_back(expect_read(c - 1));
            end else begin
                rd_en = 1'b0;
            end
            if (c < 4096) begin
                d = WIDTH'($urandom);
                wr_en = 1'b1; wr_data = d;
                mdl[wr_addr_of(c)] = d;
            end else begin
                wr_en = 1'b0;
            end
        end
        n_cmp++;
        if (popped != 4096) begin
            n_fail++; $display("[TB] FAIL pt_count got %0d want 4096", popped);
        end
    endtask

    task automatic test_wrap_overrun();
        taps_t want, last;
        int popped;
        wr_offset = 16382;
        wr_extent = '0; wr_extent[0] = 4; wr_stride = '0; wr_stride[0] = 1;
        rd_extent = '0; rd_extent[0] = 4; rd_stride = '0; rd_stride[0] = 1;
        rd_tap_offset[0] = 16382; rd_tap_offset[1] = 16383; rd_tap_offset[2] = 0; rd_tap_offset[3] = 1;
        do_flush();
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1; wr_data = WIDTH'(10 + c);
            mdl[wr_addr_of(c)] = WIDTH'(10 + c);
            @(negedge clk);
        end
        n_cmp++; if (wr_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_wr_done got %b want 1", wr_done); end
        wr_data = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (wr_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_overrun_set got %b want 1", wr_overrun); end
        n_cmp++; if (wr_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_done_hold got %b want 1", wr_done); end
        popped = 0;
        for (int c = 0; c <= 5; c++) begin
            if (rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL wrap_unexpected_valid got 1 want 0");
                end else begin
                    want = exp_q.pop_front();
                    if (rd_data !== want || rd_data[0] !== WIDTH'(10 + popped)) begin
                        n_fail++; $display("[TB] FAIL wrap_data[%0d] got %h want %h (tap0 %0d)", popped, rd_data, want, 10 + popped);
                    end
                    popped++;
                end
            end
            if (c < 4) begin
                rd_en = 1'b1;
                exp_q.push_back(expect_read(c));
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (popped != 4) begin n_fail++; $display("[TB] FAIL wrap_count got %0d want 4", popped); end
        last = rd_data;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if (rd_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_overrun_set got %b want 1", rd_overrun); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_overrun_valid got %b want 0", rd_valid); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({wr_done, wr_overrun, rd_done, rd_overrun, rd_valid} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL flush_flags got %b want 00000", {wr_done, wr_overrun, rd_done, rd_overrun, rd_valid});
        end
        n_cmp++; if (rd_data !== last) begin n_fail++; $display("[TB] FAIL flush_rd_data got %h want %h", rd_data, last); end
        wr_en = 1'b1; wr_data = 16'h0777;
        mdl[wr_addr_of(0)] = 16'h0777;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b1;
        want = expect_read(0);
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== want || rd_data[0] !== 16'h0777) begin
            n_fail++; $display("[TB] FAIL flush_rewrite got valid=%b %h want valid=1 %h", rd_valid, rd_data, want);
        end
    endtask

    task automatic test_collision();
        taps_t want;
        wr_offset = 5;
        wr_extent = '0; wr_extent[0] = 2; wr_stride = '0;
        rd_extent = '0; rd_stride = '0;
        for (int t = 0; t < TAPS; t++) rd_tap_offset[t] = 5;
        do_flush();
        wr_en = 1'b1; wr_data = 16'h1234;
        mdl[5] = 16'h1234;
        @(negedge clk);
        wr_data = 16'h5678; rd_en = 1'b1;
        exp_q.push_back(expect_read(0));
        mdl[5] = 16'h5678;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++;
        if (!rd_valid || exp_q.size() == 0) begin
            n_fail++; $display("[TB] FAIL coll_valid got %b want 1", rd_valid);
        end else begin
            want = exp_q.pop_front();
            if (rd_data !== want || rd_data[0] !== 16'h1234) begin
                n_fail++; $display("[TB] FAIL coll_data got %h want %h", rd_data, want);
            end
        end
    endtask

    task automatic test_reset_midrun();
        taps_t want;
        rd_tap_offset = '0;
        rd_extent = '0; rd_extent[0] = 64; rd_stride = '0; rd_stride[0] = 1;
        do_flush();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_valid && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                n_cmp++;
                if (rd_data !== want) begin
                    n_fail++; $display("[TB] FAIL mid_data[%0d] got %h want %h", c, rd_data, want);
                end
            end
            rd_en = 1'b1;
            exp_q.push_back(expect_read(c));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL mid_rd_data got %h want 0", rd_data); end
        n_cmp++;
        if ({wr_done, rd_done, wr_overrun, rd_overrun} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL mid_flags got %b want 0000", {wr_done, rd_done, wr_overrun, rd_overrun});
        end
        exp_q.delete();
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_downsample();
        test_passthrough();
        test_wrap_overrun();
        test_collision();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
